// File: rtl/trace_capture_engine.sv
// Triggered logic-analyser style trace buffer: a circular pre/post-trigger capture
// with ordered readout, plus a free-running FIFO stream mode with drop counting.
module trace_capture_engine #(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 256,
    parameter  int NUM_TRIG = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                CLK_I,
    input  logic                RST_NI,
    input  logic                CMD_VALID_I,
    output logic                CMD_READY_O,
    input  logic [1:0]          CMD_OP_I,
    input  logic [NUM_TRIG-1:0] CMD_TRIG_MASK_I,
    input  logic [AW:0]         CMD_POST_I,
    input  logic                TRACE_VALID_I,
    input  logic [WIDTH-1:0]    TRACE_I,
    input  logic [NUM_TRIG-1:0] TRIG_I,
    output logic                DATA_VALID_O,
    input  logic                DATA_READY_I,
    output logic [WIDTH-1:0]    DATA_O,
    output logic                DATA_LAST_O,
    output logic [2:0]          STATE_O,
    output logic [AW:0]         FILL_O,
    output logic [AW-1:0]       TRIG_PTR_O,
    output logic [15:0]         DROP_CNT_O
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_POST   = 3'd2,
        ST_DONE   = 3'd3,
        ST_STREAM = 3'd4
    } state_t;

    localparam logic [1:0]    OP_ARM    = 2'd1;
    localparam logic [1:0]    OP_ABORT  = 2'd2;
    localparam logic [1:0]    OP_STREAM = 2'd3;
    localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   FILL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_MAX   = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           fill_q, fill_d;
    logic [AW-1:0]         trig_ptr_q, trig_ptr_d;
    logic [AW-1:0]         post_cnt_q, post_cnt_d;
    logic [AW-1:0]         post_lat_q, post_lat_d;
    logic [NUM_TRIG-1:0]   mask_q, mask_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  data_valid_q, data_valid_d;
    logic                  data_last_q, data_last_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  mem_we;

    logic                  out_hs;
    logic [AW:0]           avail;
    logic                  load;

    // Words stored but not yet placed in the output register.
    assign out_hs = data_valid_q && DATA_READY_I;
    assign avail  = fill_q - (data_valid_q ? FILL_ONE : '0);
    assign load   = ((state_q == ST_DONE) || (state_q == ST_STREAM)) && (avail != '0)
                    && (!data_valid_q || DATA_READY_I);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        trig_ptr_d   = trig_ptr_q;
        post_cnt_d   = post_cnt_q;
        post_lat_d   = post_lat_q;
        mask_d       = mask_q;
        drop_cnt_d   = drop_cnt_q;
        data_valid_d = data_valid_q;
        data_last_d  = data_last_q;
        data_d       = data_q;
        mem_we       = 1'b0;

        case (state_q)
            ST_ARMED, ST_POST: begin
                if (TRACE_VALID_I) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (fill_q != FILL_FULL) fill_d = fill_q + FILL_ONE;
                    if (state_q == ST_ARMED) begin
                        if (|(TRIG_I & mask_q)) begin
                            trig_ptr_d = wr_ptr_q;
                            post_cnt_d = post_lat_q;
                            state_d    = (post_lat_q == '0) ? ST_DONE : ST_POST;
                        end
                    end else begin
                        post_cnt_d = post_cnt_q - PTR_ONE;
                        if (post_cnt_q == PTR_ONE) state_d = ST_DONE;
                    end
                end
                // Keep the read pointer on the oldest retained sample for readout.
                rd_ptr_d = wr_ptr_d - fill_d[AW-1:0];
            end
            ST_DONE: begin
                if (load) begin
                    data_d       = mem[rd_ptr_q];
                    data_valid_d = 1'b1;
                    data_last_d  = (avail == FILL_ONE);
                    rd_ptr_d     = rd_ptr_q + PTR_ONE;
                end else if (out_hs) begin
                    data_valid_d = 1'b0;
                    data_last_d  = 1'b0;
                end
                if (out_hs) begin
                    fill_d = fill_q - FILL_ONE;
                    if (data_last_q) state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // Full check uses the registered fill, before any same-cycle read.
                if (TRACE_VALID_I) begin
                    if (fill_q != FILL_FULL) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end else if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end
                if (load) begin
                    data_d       = mem[rd_ptr_q];
                    data_valid_d = 1'b1;
                    rd_ptr_d     = rd_ptr_q + PTR_ONE;
                end else if (out_hs) begin
                    data_valid_d = 1'b0;
                end
                data_last_d = 1'b0;
                if (mem_we && !out_hs) fill_d = fill_q + FILL_ONE;
                else if (!mem_we && out_hs) fill_d = fill_q - FILL_ONE;
            end
            default: ;
        endcase

        if (CMD_VALID_I) begin
            case (CMD_OP_I)
                OP_ARM: begin
                    if (state_q == ST_IDLE) begin
                        mask_d       = CMD_TRIG_MASK_I;
                        post_lat_d   = CMD_POST_I[AW] ? PTR_MAX : CMD_POST_I[AW-1:0];
                        wr_ptr_d     = '0;
                        rd_ptr_d     = '0;
                        fill_d       = '0;
                        trig_ptr_d   = '0;
                        data_valid_d = 1'b0;
                        data_last_d  = 1'b0;
                        state_d      = ST_ARMED;
                    end
                end
                OP_STREAM: begin
                    if (state_q == ST_IDLE) begin
                        wr_ptr_d     = '0;
                        rd_ptr_d     = '0;
                        fill_d       = '0;
                        drop_cnt_d   = '0;
                        data_valid_d = 1'b0;
                        data_last_d  = 1'b0;
                        state_d      = ST_STREAM;
                    end
                end
                OP_ABORT: begin
                    fill_d       = '0;
                    data_valid_d = 1'b0;
                    data_last_d  = 1'b0;
                    state_d      = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (mem_we) mem[wr_ptr_q] <= TRACE_I;
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            trig_ptr_q   <= '0;
            post_cnt_q   <= '0;
            post_lat_q   <= '0;
            mask_q       <= '0;
            drop_cnt_q   <= '0;
            data_valid_q <= 1'b0;
            data_last_q  <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            trig_ptr_q   <= trig_ptr_d;
            post_cnt_q   <= post_cnt_d;
            post_lat_q   <= post_lat_d;
            mask_q       <= mask_d;
            drop_cnt_q   <= drop_cnt_d;
            data_valid_q <= data_valid_d;
            data_last_q  <= data_last_d;
            data_q       <= data_d;
        end
    end

    assign CMD_READY_O  = 1'b1;
    assign DATA_VALID_O = data_valid_q;
    assign DATA_O       = data_q;
    assign DATA_LAST_O  = data_last_q;
    assign STATE_O      = state_q;
    assign FILL_O       = fill_q;
    assign TRIG_PTR_O   = trig_ptr_q;
    assign DROP_CNT_O   = drop_cnt_q;

endmodule

// File: tb/tb_trace_capture_engine.sv
// Scenario bench for trace_capture_engine (DEPTH=16): expected readout words are
// queued as samples are driven and checked against each output handshake.
module tb_trace_capture_engine;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int NT    = 4;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [NT-1:0]    cmd_mask;
    logic [AW:0]      cmd_post;
    logic             trace_valid;
    logic [WIDTH-1:0] trace;
    logic [NT-1:0]    trig;
    logic             data_valid;
    logic             data_ready;
    logic [WIDTH-1:0] data;
    logic             data_last;
    logic [2:0]       state;
    logic [AW:0]      fill;
    logic [AW-1:0]    trig_ptr;
    logic [15:0]      drop_cnt;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] sb[$];

    always #5 clk = ~clk;

    trace_capture_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_TRIG(NT)) dut (
        .CLK_I(clk), .RST_NI(rst_n),
        .CMD_VALID_I(cmd_valid), .CMD_READY_O(cmd_ready), .CMD_OP_I(cmd_op),
        .CMD_TRIG_MASK_I(cmd_mask), .CMD_POST_I(cmd_post),
        .TRACE_VALID_I(trace_valid), .TRACE_I(trace), .TRIG_I(trig),
        .DATA_VALID_O(data_valid), .DATA_READY_I(data_ready), .DATA_O(data),
        .DATA_LAST_O(data_last), .STATE_O(state), .FILL_O(fill),
        .TRIG_PTR_O(trig_ptr), .DROP_CNT_O(drop_cnt)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [NT-1:0] mask, input int post);
        cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; cmd_post = (AW+1)'(post);
        step();
        cmd_valid = 1'b0; cmd_op = 2'd0;
    endtask

    // Drains the scoreboard via output handshakes, optionally with random stalls.
    task automatic read_out(input int budget, input bit stall, input bit cap);
        int cyc = 0;
        bit rdy, hs, held_v, exp_last;
        logic [WIDTH-1:0] held = '0;
        held_v = 1'b0;
        while (sb.size() > 0 && cyc < budget) begin
            if (held_v) begin
                total++;
                if (data_valid !== 1'b1 || data !== held) begin
                    bad++;
                    $display("FAIL stall_hold got valid=%0b data=%0h want valid=1 data=%0h", data_valid, data, held);
                end
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (data_valid === 1'b1) begin
                exp_last = cap && (sb.size() == 1);
                total++;
                if (data !== sb[0]) begin
                    bad++;
                    $display("FAIL rd_data got=%0h want=%0h", data, sb[0]);
                end
                total++;
                if (data_last !== exp_last) begin
                    bad++;
                    $display("FAIL rd_last got=%0b want=%0b (word %0h)", data_last, exp_last, sb[0]);
                end
                $display("read word %0h last=%0b", data, data_last);
            end
            hs     = (data_valid === 1'b1) && rdy;
            held_v = (data_valid === 1'b1) && !rdy;
            held   = data;
            data_ready = rdy;
            step();
            if (hs) void'(sb.pop_front());
            cyc++;
        end
        data_ready = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL rd_timeout got left=%0d want left=0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (state !== 3'd0)      begin bad++; $display("FAIL rst_state got=%0d want=0", state); end
        total++; if (fill !== '0)         begin bad++; $display("FAIL rst_fill got=%0d want=0", fill); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", data_valid); end
        total++; if (data_last !== 1'b0)  begin bad++; $display("FAIL rst_last got=%0b want=0", data_last); end
        total++; if (data !== '0)         begin bad++; $display("FAIL rst_data got=%0h want=0", data); end
        total++; if (drop_cnt !== 16'd0)  begin bad++; $display("FAIL rst_drop got=%0d want=0", drop_cnt); end
        total++; if (trig_ptr !== '0)     begin bad++; $display("FAIL rst_trigptr got=%0d want=0", trig_ptr); end
        total++; if (cmd_ready !== 1'b1)  begin bad++; $display("FAIL rst_ready got=%0b want=1", cmd_ready); end
        step(); step();
        rst_n = 1'b1;
        step();
        $display("reset done state=%0d", state);
    endtask

    task automatic test_basic_capture();
        sb.delete();
        send_cmd(2'd1, 4'b0001, 3);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL basic_armed got=%0d want=1", state); end
        for (int i = 0; i < 10; i++) begin
            trace_valid = 1'b1; trace = WIDTH'(i); trig = (i == 5) ? 4'b0001 : 4'b0000;
            if (i <= 8) sb.push_back(WIDTH'(i));
            step();
            if (i == 7) begin
                total++; if (state !== 3'd2) begin bad++; $display("FAIL basic_post got=%0d want=2", state); end
            end
            if (i == 8) begin
                total++; if (state !== 3'd3) begin bad++; $display("FAIL basic_done got=%0d want=3", state); end
            end
        end
        trace_valid = 1'b0; trig = '0;
        total++; if (trig_ptr !== 4'd5) begin bad++; $display("FAIL basic_trigptr got=%0d want=5", trig_ptr); end
        total++; if (fill !== 5'd9)     begin bad++; $display("FAIL basic_fill got=%0d want=9", fill); end
        read_out(60, 1'b0, 1'b1);
        total++; if (state !== 3'd0)      begin bad++; $display("FAIL basic_idle got=%0d want=0", state); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_off got=%0b want=0", data_valid); end
        total++; if (fill !== '0)         begin bad++; $display("FAIL basic_fill_end got=%0d want=0", fill); end
    endtask

    task automatic test_wrap_capture();
        sb.delete();
        send_cmd(2'd1, 4'b0001, 4);
        for (int i = 0; i < 40; i++) begin
            trace_valid = 1'b1; trace = WIDTH'(i); trig = (i == 30) ? 4'b0001 : 4'b0000;
            if (i >= 19 && i <= 34) sb.push_back(WIDTH'(i));
            step();
        end
        trace_valid = 1'b0; trig = '0;
        total++; if (state !== 3'd3)     begin bad++; $display("FAIL wrap_done got=%0d want=3", state); end
        total++; if (fill !== 5'd16)     begin bad++; $display("FAIL wrap_fill got=%0d want=16", fill); end
        total++; if (trig_ptr !== 4'd14) begin bad++; $display("FAIL wrap_trigptr got=%0d want=14", trig_ptr); end
        read_out(300, 1'b1, 1'b1);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL wrap_idle got=%0d want=0", state); end
    endtask

    task automatic test_mask();
        sb.delete();
        send_cmd(2'd1, 4'b0100, 0);
        send_cmd(2'd3, 4'b0000, 0);
        total++; if (state !== 3'd1) begin bad++; $display("FAIL mask_stream_ignored got=%0d want=1", state); end
        trace_valid = 1'b1; trace = 32'h11; trig = 4'b0001;
        step();
        trace_valid = 1'b0; trig = '0;
        total++; if (state !== 3'd1) begin bad++; $display("FAIL mask_unmasked_trig got=%0d want=1", state); end
        send_cmd(2'd2, 4'b0000, 0);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL mask_abort got=%0d want=0", state); end
        total++; if (fill !== '0)    begin bad++; $display("FAIL mask_abort_fill got=%0d want=0", fill); end
        send_cmd(2'd1, 4'b0100, 0);
        trig = 4'b0001; step(); step();
        trace_valid = 1'b1; trace = 32'hCAFE; trig = 4'b0100;
        sb.push_back(32'hCAFE);
        step();
        trace_valid = 1'b0; trig = '0;
        total++; if (state !== 3'd3) begin bad++; $display("FAIL mask_done got=%0d want=3", state); end
        total++; if (fill !== 5'd1)  begin bad++; $display("FAIL mask_fill got=%0d want=1", fill); end
        read_out(20, 1'b0, 1'b1);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL mask_idle got=%0d want=0", state); end
    endtask

    task automatic test_stream();
        logic [AW:0] fill_ref = '0;
        bit hs;
        sb.delete();
        data_ready = 1'b0;
        send_cmd(2'd3, 4'b0000, 0);
        total++; if (state !== 3'd4) begin bad++; $display("FAIL stream_state got=%0d want=4", state); end
        for (int i = 0; i < 20; i++) begin
            trace_valid = 1'b1; trace = WIDTH'(100 + i);
            if (i < 16) sb.push_back(WIDTH'(100 + i));
            step();
        end
        trace_valid = 1'b0;
        total++; if (fill !== 5'd16)      begin bad++; $display("FAIL stream_fill got=%0d want=16", fill); end
        total++; if (drop_cnt !== 16'd4)  begin bad++; $display("FAIL stream_drop got=%0d want=4", drop_cnt); end
        read_out(300, 1'b1, 1'b0);
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL stream_empty_valid got=%0b want=0", data_valid); end
        total++; if (fill !== '0)         begin bad++; $display("FAIL stream_empty_fill got=%0d want=0", fill); end
        // Back-to-back: continuous writes with the consumer always ready.
        data_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            trace_valid = 1'b1; trace = WIDTH'(200 + i);
            sb.push_back(WIDTH'(200 + i));
            hs = (data_valid === 1'b1);
            if (hs) begin
                total++;
                if (data !== sb[0]) begin bad++; $display("FAIL b2b_data got=%0h want=%0h", data, sb[0]); end
                $display("b2b word %0h fill=%0d", data, fill);
            end
            if (i == 4) fill_ref = fill;
            if (i > 4) begin
                total++;
                if (fill !== fill_ref) begin bad++; $display("FAIL b2b_fill got=%0d want=%0d", fill, fill_ref); end
            end
            step();
            if (hs) void'(sb.pop_front());
        end
        trace_valid = 1'b0;
        read_out(20, 1'b0, 1'b0);
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b want=0", data_valid); end
        send_cmd(2'd2, 4'b0000, 0);
        total++; if (state !== 3'd0)      begin bad++; $display("FAIL stream_abort got=%0d want=0", state); end
        total++; if (drop_cnt !== 16'd4)  begin bad++; $display("FAIL stream_drop_kept got=%0d want=4", drop_cnt); end
    endtask

    task automatic test_abort_readout();
        sb.delete();
        send_cmd(2'd1, 4'b0001, 2);
        for (int i = 0; i < 4; i++) begin
            trace_valid = 1'b1; trace = WIDTH'(32'h50 + i); trig = (i == 1) ? 4'b0001 : 4'b0000;
            step();
        end
        trace_valid = 1'b0; trig = '0;
        total++; if (state !== 3'd3) begin bad++; $display("FAIL abort_done got=%0d want=3", state); end
        step();
        total++; if (data_valid !== 1'b1 || data !== 32'h50) begin
            bad++; $display("FAIL abort_first got valid=%0b data=%0h want valid=1 data=50", data_valid, data);
        end
        data_ready = 1'b1; step(); data_ready = 1'b0;
        total++; if (data !== 32'h51) begin bad++; $display("FAIL abort_second got=%0h want=51", data); end
        send_cmd(2'd2, 4'b0000, 0);
        total++; if (state !== 3'd0)      begin bad++; $display("FAIL abort_state got=%0d want=0", state); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%0b want=0", data_valid); end
        total++; if (fill !== '0)         begin bad++; $display("FAIL abort_fill got=%0d want=0", fill); end
        total++; if (trig_ptr !== 4'd1)   begin bad++; $display("FAIL abort_trigptr got=%0d want=1", trig_ptr); end
    endtask

    task automatic test_reset_in_post();
        sb.delete();
        send_cmd(2'd1, 4'b0001, 5);
        for (int i = 0; i < 3; i++) begin
            trace_valid = 1'b1; trace = WIDTH'(i); trig = (i == 1) ? 4'b0001 : 4'b0000;
            step();
        end
        trace_valid = 1'b0; trig = '0;
        total++; if (state !== 3'd2) begin bad++; $display("FAIL rpost_post got=%0d want=2", state); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (state !== 3'd0)      begin bad++; $display("FAIL rpost_state got=%0d want=0", state); end
        total++; if (fill !== '0)         begin bad++; $display("FAIL rpost_fill got=%0d want=0", fill); end
        total++; if (trig_ptr !== '0)     begin bad++; $display("FAIL rpost_trigptr got=%0d want=0", trig_ptr); end
        total++; if (drop_cnt !== 16'd0)  begin bad++; $display("FAIL rpost_drop got=%0d want=0", drop_cnt); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rpost_valid got=%0b want=0", data_valid); end
        total++; if (cmd_ready !== 1'b1)  begin bad++; $display("FAIL rpost_ready got=%0b want=1", cmd_ready); end
        step();
        rst_n = 1'b1;
        step();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rpost_release got=%0d want=0", state); end
        send_cmd(2'd1, 4'b0010, 1);
        for (int i = 0; i < 2; i++) begin
            trace_valid = 1'b1; trace = WIDTH'(32'h300 + i); trig = (i == 0) ? 4'b0010 : 4'b0000;
            sb.push_back(WIDTH'(32'h300 + i));
            step();
        end
        trace_valid = 1'b0; trig = '0;
        total++; if (state !== 3'd3) begin bad++; $display("FAIL rpost_recap got=%0d want=3", state); end
        read_out(30, 1'b1, 1'b1);
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rpost_idle got=%0d want=0", state); end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_mask = '0; cmd_post = '0;
        trace_valid = 1'b0; trace = '0; trig = '0; data_ready = 1'b0;
        test_reset();
        test_basic_capture();
        test_wrap_capture();
        test_mask();
        test_stream();
        test_abort_readout();
        test_reset_in_post();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trace_capture_engine.md
TRACE_CAPTURE_ENGINE -- requirements
Module: trace_capture_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, trace sample and readout word width.
REQ-002 SHALL have parameter DEPTH, default 256, sample storage depth (power of two, >=4); AW = log2(DEPTH).
REQ-003 SHALL have parameter NUM_TRIG, default 4, number of independent trigger sources.
REQ-004 SHALL have ports: CLK_I in 1, single clock; RST_NI in 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports: CMD_VALID_I in 1, command strobe; CMD_READY_O out 1, command accepted; CMD_OP_I in 2, 1=ARM 2=ABORT 3=STREAM (0 ignored).
REQ-006 SHALL have ports: CMD_TRIG_MASK_I in NUM_TRIG, trigger enable mask; CMD_POST_I in AW+1, post-trigger sample count.
REQ-007 SHALL have ports: TRACE_VALID_I in 1, sample present; TRACE_I in WIDTH, sample; TRIG_I in NUM_TRIG, trigger sources.
REQ-008 SHALL have ports: DATA_VALID_O out 1; DATA_READY_I in 1; DATA_O out WIDTH; DATA_LAST_O out 1, final word of capture.
REQ-009 SHALL have ports: STATE_O out 3; FILL_O out AW+1, stored words; TRIG_PTR_O out AW, trigger sample address; DROP_CNT_O out 16, stream drops.

Function
REQ-010 SHALL implement states IDLE(0), ARMED(1), POST(2), DONE(3), STREAM(4); STATE_O shows current state.
REQ-011 SHALL hold CMD_READY_O=1 in every state; command takes effect on the cycle after CMD_VALID_I&&CMD_READY_O.
REQ-012 ARM SHALL be honoured only in IDLE: latch mask and min(CMD_POST_I, DEPTH-1); clear wr_ptr, FILL_O, TRIG_PTR_O; go ARMED.
REQ-013 STREAM SHALL be honoured only in IDLE: clear pointers, FILL_O, DROP_CNT_O; go STREAM.
REQ-014 ABORT SHALL, from any state, go IDLE, clear FILL_O, deassert DATA_VALID_O; DROP_CNT_O, TRIG_PTR_O retained.
REQ-015 In ARMED/POST each TRACE_VALID_I cycle SHALL write TRACE_I at wr_ptr, increment wr_ptr mod DEPTH, and increment FILL_O saturating at DEPTH.
REQ-016 Trigger SHALL be |(TRIG_I & mask) && TRACE_VALID_I in ARMED; that sample is the trigger sample, TRIG_PTR_O := its address, post counter := latched post.
REQ-017 Trigger cycle with post=0 SHALL go DONE next cycle; otherwise POST; triggers in POST/DONE ignored.
REQ-018 In POST each written sample SHALL decrement post counter; write that reaches 0 goes DONE next cycle; no writes in DONE.
REQ-019 DONE SHALL stream FILL_O words from oldest (wr_ptr-FILL_O mod DEPTH) upward with wrap; DATA_LAST_O on final word only.
REQ-020 DATA_O/DATA_VALID_O/DATA_LAST_O SHALL be registered and stable while DATA_VALID_O&&!DATA_READY_I; first word valid <=2 cycles after entering DONE.
REQ-021 After final handshake in DONE SHALL go IDLE next cycle; FILL_O decrements per handshake.
REQ-022 STREAM SHALL act as FIFO: write when TRACE_VALID_I and FILL_O<DEPTH; read per output handshake in order; DATA_LAST_O=0.
REQ-023 In STREAM, sample arriving with FILL_O==DEPTH (evaluated before same-cycle read) SHALL drop; DROP_CNT_O increments saturating at 16'hFFFF.
REQ-024 Simultaneous write and read in STREAM SHALL leave FILL_O unchanged; empty FIFO SHALL hold DATA_VALID_O=0.
REQ-025 ARM/STREAM received outside IDLE SHALL be ignored with no state change; CMD_OP_I=0 ignored.
REQ-026 Storage SHALL be a single-port-write, single-read array of DEPTH x WIDTH; pointers AW bits, wrap naturally.

Reset
REQ-027 RST_NI low SHALL asynchronously force IDLE, all pointers/counters 0, DATA_VALID_O=0, DATA_LAST_O=0, DATA_O=0, DROP_CNT_O=0, TRIG_PTR_O=0, FILL_O=0; CMD_READY_O=1.
REQ-028 Reset mid-capture or mid-readout SHALL discard contents; first cycle after release is IDLE; stored array contents need not clear.

Verification
REQ-029 DEPTH=16: ARM post=3, samples 0..9, trigger on sample 5 -> DONE after sample 8, TRIG_PTR_O=5, readout 0..8, LAST on 8.
REQ-030 DEPTH=16: ARM post=4, 40 samples value=i, trigger at i=30 -> FILL_O=16, readout 19..34 in order, wrap handled, LAST on 34.
REQ-031 ARM post=0, trigger on first sample with mask bit 2 only; TRIG_I[0] pulses earlier ignored -> one-word readout, LAST=1.
REQ-032 STREAM, DATA_READY_I=0, 20 samples, DEPTH=16 -> FILL_O=16, DROP_CNT_O=4, then readout 0..15 in order.
REQ-033 Readout with random DATA_READY_I stalls -> no word lost/duplicated, DATA_O stable while stalled; ABORT mid-readout -> IDLE, DATA_VALID_O=0 next cycle.
REQ-034 RST_NI asserted during POST -> outputs at reset values asynchronously; subsequent ARM captures correctly.
